exception_ctrl: RTL
===================

// Module: exception_ctrl
// PURPOSE
// Parametrised, registered exception/interrupt controller sitting at the commit point beside CP0.
// Synchronises N_HWINT external interrupt lines and prioritises N_EXC per-instruction exception requests plus ERET.
// Produces CP0 update pulses (Cause/EPC/BadVAddr/EXL) and holds a flush/redirect request until the fetch stage accepts it.
// Supports BEV-dependent vectors and nested-exception (EXL=1) EPC protection.
// PARAMETERS
// N_HWINT      6             external hardware interrupt lines (Cause.IP[2+N_HWINT-1:2]), 1..6
// N_EXC        8             per-instruction exception request bits; index 0 = highest priority
// SYNC_STAGES  2             interrupt synchroniser depth, >=2
// VEC_BEV      32'hBFC00380  handler entry when Status.BEV=1
// VEC_NORM     32'h80000180  handler entry when Status.BEV=0
// PORTS
// clk             in   1        core clock
// resetn          in   1        asynchronous active-low reset
// hw_int          in   N_HWINT  raw async interrupt lines, level-sensitive
// sw_int          in   2        Cause.IP[1:0]
// status_ie/exl/erl/bev in 1 each  current CP0 Status bits
// status_im       in   8        Status.IM
// commit_valid    in   1        instruction presented at commit this cycle
// commit_ready    out  1        1 iff state==IDLE
// commit_pc       in   32       PC of committing instruction
// commit_in_ds    in   1        instruction is in a delay slot
// commit_exc      in   N_EXC    exception request bits
// commit_badvaddr in   32       faulting address for address-error bits
// commit_eret     in   1        instruction is ERET
// epc             in   32       current CP0 EPC
// ip_pending      out  8        synchronised Cause.IP view {hw_sync, sw_int}
// cp0_exc_we      out  1        1-cycle pulse: write Cause.ExcCode/BD, set EXL
// cp0_epc_we      out  1        1-cycle pulse: write EPC (suppressed when EXL was 1)
// cp0_bva_we      out  1        1-cycle pulse: write BadVAddr
// cp0_eret        out  1        1-cycle pulse: clear EXL
// cp0_exccode     out  5        ExcCode for write
// cp0_bd          out  1        Cause.BD value
// cp0_epc         out  32       EPC value: delay-slot ? pc-4 : pc
// cp0_badvaddr    out  32       BadVAddr value
// flush           out  1        1-cycle pulse: flush all stages older than commit
// redirect_valid  out  1        redirect request, held until accepted
// redirect_ready  in   1        fetch accepts redirect
// redirect_pc     out  32       handler vector or EPC (ERET)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, every output and synchroniser flop = 0; commit_ready becomes 1 after release.
// - Synchroniser: hw_int passes through SYNC_STAGES flops; ip_pending = {hw_sync, sw_int}, zero-padded to 8 bits.
// - int_req = |(ip_pending & status_im) & status_ie & ~status_exl & ~status_erl.
// - FSM IDLE: a take occurs in cycle T iff commit_valid and (int_req | |commit_exc | commit_eret).
//   - Priority: interrupt > commit_exc lowest set index > eret. Exception with eret set: exception wins, no cp0_eret.
//   - Interrupt or exception: at T+1 pulse cp0_exc_we and flush; cp0_epc_we = ~status_exl sampled at T.
//     cp0_bva_we only for AdEL/AdES codes. redirect_pc = status_bev ? VEC_BEV : VEC_NORM.
//   - ERET: at T+1 pulse cp0_eret and flush; redirect_pc = epc sampled at T.
//   - redirect_valid rises at T+1 and the FSM enters REDIRECT.
// - FSM REDIRECT: redirect_valid and redirect_pc are held stable; commit_ready=0 and commit inputs are ignored.
//   - Handshake: on redirect_valid & redirect_ready, go to IDLE next cycle. Ready at T+1 gives one bubble.
//   - Interrupts arriving meanwhile stay pending; they are taken at the first commit after return to IDLE.
//     Status changes written at T+1 are visible by then.
// - No take: all pulses stay 0 and commit_ready stays 1 (pure pass-through).
// - Latency: decision to CP0 write / redirect = 1 cycle registered; no combinational commit->redirect path.
// STRUCTURE
// - Shared package (exc_pkg): exc_code_t, CODE_* constants, exc_index->ExcCode table (N_EXC entries),
//   is_addr_err() function, exc_state_t {IDLE, REDIRECT}.
// - Sub-module irq_sync: parametrised N-bit, SYNC_STAGES-deep synchroniser with async active-low clear.
// TESTING
// - hw_int[0]=1 async, IE=1, IM[2]=1, EXL=0, commit pc=0x80001000 in_ds=0:
//   after SYNC_STAGES+1 cycles ip_pending[2]=1; next commit -> exccode 0, epc 0x80001000, redirect 0x80000180.
// - commit_exc = RI|OV bits, commit_in_ds=1, pc=0x80000104:
//   RI code 0x0A, cp0_bd=1, cp0_epc=0x80000100, cp0_bva_we=0.
// - AdEL with badvaddr 0x00000003 and BEV=1: cp0_bva_we=1, badvaddr 0x3, redirect_pc 0xBFC00380.
// - EXL=1 plus OV exception: cp0_exc_we=1, cp0_epc_we=0.
// - ERET with epc=0x80002000: cp0_eret pulse, redirect 0x80002000.
//   Hold redirect_ready=0 for 5 cycles: redirect held, commit_ready=0, all pulses 1 cycle only.
// - Assert resetn=0 while in REDIRECT: redirect_valid and flush drop immediately, IDLE after release.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared types for the commit-point exception controller: ExcCode values,
// the request-bit to ExcCode priority table and the controller state encoding.
package exc_pkg;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t CODE_INT  = 5'h00;
  localparam exc_code_t CODE_ADEL = 5'h04;
  localparam exc_code_t CODE_ADES = 5'h05;
  localparam exc_code_t CODE_SYS  = 5'h08;
  localparam exc_code_t CODE_BP   = 5'h09;
  localparam exc_code_t CODE_RI   = 5'h0A;
  localparam exc_code_t CODE_CPU  = 5'h0B;
  localparam exc_code_t CODE_OV   = 5'h0C;
  localparam exc_code_t CODE_TR   = 5'h0D;

  // Request bit index -> ExcCode. Index 0 is the highest priority; fetch-side
  // address errors come first, data-side address errors last.
  function automatic exc_code_t exc_code_of(input int idx);
    exc_code_t code;
    case (idx)
      0:       code = CODE_ADEL;
      1:       code = CODE_RI;
      2:       code = CODE_CPU;
      3:       code = CODE_SYS;
      4:       code = CODE_BP;
      5:       code = CODE_OV;
      6:       code = CODE_ADEL;
      7:       code = CODE_ADES;
      default: code = CODE_TR;
    endcase
    return code;
  endfunction

  function automatic logic is_addr_err(input exc_code_t code);
    return (code == CODE_ADEL) || (code == CODE_ADES);
  endfunction

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } exc_state_t;

endpackage

// File: rtl/exception_ctrl_irq_sync.sv
// Multi-bit level synchroniser for asynchronous interrupt lines.
// STAGES flops deep; cleared asynchronously by rst_n.
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// Commit-point exception/interrupt controller: prioritises interrupts, exceptions and ERET,
// emits registered CP0 update pulses one cycle after the decision and holds a redirect until fetch accepts it.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          N_HWINT     = 6,
  parameter int          N_EXC       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BEV     = 32'hBFC0_0380,
  parameter logic [31:0] VEC_NORM    = 32'h8000_0180
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic [1:0]         sw_int,
  input  logic               status_ie,
  input  logic               status_exl,
  input  logic               status_erl,
  input  logic               status_bev,
  input  logic [7:0]         status_im,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic [31:0]        commit_pc,
  input  logic               commit_in_ds,
  input  logic [N_EXC-1:0]   commit_exc,
  input  logic [31:0]        commit_badvaddr,
  input  logic               commit_eret,
  input  logic [31:0]        epc,
  output logic [7:0]         ip_pending,
  output logic               cp0_exc_we,
  output logic               cp0_epc_we,
  output logic               cp0_bva_we,
  output logic               cp0_eret,
  output logic [4:0]         cp0_exccode,
  output logic               cp0_bd,
  output logic [31:0]        cp0_epc,
  output logic [31:0]        cp0_badvaddr,
  output logic               flush,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [31:0]        redirect_pc
);

  logic [N_HWINT-1:0] hw_sync;

  irq_sync #(
    .WIDTH (N_HWINT),
    .STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk  (clk),
    .rst_n(resetn),
    .d    (hw_int),
    .q    (hw_sync)
  );

  always_comb begin
    ip_pending                  = '0;
    ip_pending[1:0]             = sw_int;
    ip_pending[2 +: N_HWINT]    = hw_sync;
  end

  logic int_req;
  assign int_req = (|(ip_pending & status_im)) & status_ie & ~status_exl & ~status_erl;

  // Lowest set request index wins: scan from the top so lower indices overwrite.
  logic      exc_any;
  exc_code_t exc_sel;
  always_comb begin
    exc_sel = CODE_INT;
    for (int i = N_EXC - 1; i >= 0; i--) begin
      if (commit_exc[i]) begin
        exc_sel = exc_code_of(i);
      end
    end
  end
  assign exc_any = |commit_exc;

  exc_state_t  state_q, state_d;
  logic        ready_q, ready_d;
  logic        exc_we_q, exc_we_d;
  logic        epc_we_q, epc_we_d;
  logic        bva_we_q, bva_we_d;
  logic        eret_q, eret_d;
  logic        flush_q, flush_d;
  logic        rvld_q, rvld_d;
  exc_code_t   code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_val_q, epc_val_d;
  logic [31:0] bva_q, bva_d;
  logic [31:0] rpc_q, rpc_d;
  exc_code_t   take_code;

  always_comb begin
    state_d   = state_q;
    exc_we_d  = 1'b0;
    epc_we_d  = 1'b0;
    bva_we_d  = 1'b0;
    eret_d    = 1'b0;
    flush_d   = 1'b0;
    rvld_d    = rvld_q;
    code_d    = code_q;
    bd_d      = bd_q;
    epc_val_d = epc_val_q;
    bva_d     = bva_q;
    rpc_d     = rpc_q;
    take_code = int_req ? CODE_INT : exc_sel;

    case (state_q)
      IDLE: begin
        // ready_q stays low for the first cycle after reset release.
        if (ready_q && commit_valid && (int_req || exc_any || commit_eret)) begin
          state_d = REDIRECT;
          flush_d = 1'b1;
          rvld_d  = 1'b1;
          if (int_req || exc_any) begin
            exc_we_d  = 1'b1;
            epc_we_d  = ~status_exl;
            code_d    = take_code;
            bd_d      = commit_in_ds;
            epc_val_d = commit_in_ds ? (commit_pc - 32'd4) : commit_pc;
            rpc_d     = status_bev ? VEC_BEV : VEC_NORM;
            if (!int_req && is_addr_err(take_code)) begin
              bva_we_d = 1'b1;
              bva_d    = commit_badvaddr;
            end
          end else begin
            eret_d = 1'b1;
            rpc_d  = epc;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
          rvld_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rvld_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      exc_we_q  <= 1'b0;
      epc_we_q  <= 1'b0;
      bva_we_q  <= 1'b0;
      eret_q    <= 1'b0;
      flush_q   <= 1'b0;
      rvld_q    <= 1'b0;
      code_q    <= CODE_INT;
      bd_q      <= 1'b0;
      epc_val_q <= '0;
      bva_q     <= '0;
      rpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      exc_we_q  <= exc_we_d;
      epc_we_q  <= epc_we_d;
      bva_we_q  <= bva_we_d;
      eret_q    <= eret_d;
      flush_q   <= flush_d;
      rvld_q    <= rvld_d;
      code_q    <= code_d;
      bd_q      <= bd_d;
      epc_val_q <= epc_val_d;
      bva_q     <= bva_d;
      rpc_q     <= rpc_d;
    end
  end

  assign commit_ready   = ready_q;
  assign cp0_exc_we     = exc_we_q;
  assign cp0_epc_we     = epc_we_q;
  assign cp0_bva_we     = bva_we_q;
  assign cp0_eret       = eret_q;
  assign cp0_exccode    = code_q;
  assign cp0_bd         = bd_q;
  assign cp0_epc        = epc_val_q;
  assign cp0_badvaddr   = bva_q;
  assign flush          = flush_q;
  assign redirect_valid = rvld_q;
  assign redirect_pc    = rpc_q;

endmodule
